// File: rtl/hseq_pkg.sv
// Shared types and checksum helper for the hseq message source and its checkers.
// Supplies default field widths when the NS_* size macros are not already defined.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 8
`endif

package hseq_pkg;
    localparam int HSEQ_CNT_SZ = 16;
    localparam int HSEQ_MAX_W  = 64;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } hseq_state_t;

    // Sum is taken modulo 2^op_w, op_w being the wider of the address and data fields.
    function automatic logic [HSEQ_MAX_W-1:0] hseq_red(
        input logic [HSEQ_MAX_W-1:0] src,
        input logic [HSEQ_MAX_W-1:0] dst,
        input logic [HSEQ_MAX_W-1:0] dat,
        input int                    op_w
    );
        logic [HSEQ_MAX_W-1:0] sum;
        logic [HSEQ_MAX_W-1:0] mask;
        sum  = src + dst + dat;
        mask = (op_w >= HSEQ_MAX_W) ? '1 : ((64'd1 << op_w) - 64'd1);
        return sum & mask;
    endfunction
endpackage

// File: rtl/hseq_red_gen.sv
// Combinational redundancy field: (src + dst + dat) at max(ASZ,DSZ) bits, truncated to RSZ.
module hseq_red_gen
    import hseq_pkg::*;
#(
    parameter int ASZ = 8,
    parameter int DSZ = 16,
    parameter int RSZ = 8
) (
    input  logic [ASZ-1:0] i_src,
    input  logic [ASZ-1:0] i_dst,
    input  logic [DSZ-1:0] i_dat,
    output logic [RSZ-1:0] o_red
);
    localparam int MW = (ASZ > DSZ) ? ASZ : DSZ;

    assign o_red = RSZ'(hseq_red(HSEQ_MAX_W'(i_src), HSEQ_MAX_W'(i_dst),
                                 HSEQ_MAX_W'(i_dat), MW));
endmodule

// File: rtl/hseq_source.sv
// Finite message source on a two-phase req/ack channel; NUM_MSGS=0 never sends.
// Optional HSEQ_SOURCE_STALL_CNT_EN adds stall_cnt, the saturating count of unaccepted ST_WAIT cycles.
module hseq_source
    import hseq_pkg::*;
#(
    parameter int             ASZ       = `NS_ADDRESS_SIZE,
    parameter int             DSZ       = `NS_DATA_SIZE,
    parameter int             RSZ       = `NS_REDUN_SIZE,
    parameter int             NUM_MSGS  = 8,
    parameter logic [ASZ-1:0] SRC_ADDR  = 0,
    parameter logic [ASZ-1:0] DST_ADDR  = 1,
    parameter logic [DSZ-1:0] DAT_START = 0,
    parameter logic [DSZ-1:0] DAT_STEP  = 1
) (
    input  logic             gch_clk,
    input  logic             gch_reset,
    output logic             gch_ready,
    output logic [ASZ-1:0]   snd0_src,
    output logic [ASZ-1:0]   snd0_dst,
    output logic [DSZ-1:0]   snd0_dat,
    output logic [RSZ-1:0]   snd0_red,
    output logic             snd0_req_out,
    input  logic             snd0_ack_in,
    output logic [1:0]       dbg_state,
    output logic             done
`ifdef HSEQ_SOURCE_STALL_CNT_EN
    ,
    output logic [HSEQ_CNT_SZ-1:0] stall_cnt
`endif
);
    localparam logic [HSEQ_CNT_SZ-1:0] LAST_K = HSEQ_CNT_SZ'(NUM_MSGS - 1);

    hseq_state_t            r_state;
    logic [HSEQ_CNT_SZ-1:0] r_k;
    logic [DSZ-1:0]         r_acc;
    logic [ASZ-1:0]         r_src;
    logic [ASZ-1:0]         r_dst;
    logic [DSZ-1:0]         r_dat;
    logic [RSZ-1:0]         r_red;
    logic                   r_req;
    logic                   r_ready;
    logic                   r_done;
    logic [RSZ-1:0]         w_red;
    logic                   w_accept;

    // Channel: a message is pending while req != ack; equality again means accepted.
    assign w_accept = (snd0_ack_in == r_req);

    hseq_red_gen #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) u_red (
        .i_src (SRC_ADDR),
        .i_dst (DST_ADDR),
        .i_dat (r_acc),
        .o_red (w_red)
    );

    // r_acc runs ahead of r_dat so the presented fields keep the last message in ST_DONE.
    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            r_state <= ST_INIT;
            r_k     <= '0;
            r_acc   <= DAT_START;
            r_src   <= '0;
            r_dst   <= '0;
            r_dat   <= '0;
            r_red   <= '0;
            r_req   <= 1'b0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_ready <= 1'b1;
                    if (NUM_MSGS == 0) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_src   <= SRC_ADDR;
                    r_dst   <= DST_ADDR;
                    r_dat   <= r_acc;
                    r_red   <= w_red;
                    r_req   <= ~r_req;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (w_accept) begin
                        r_k   <= r_k + 1'b1;
                        r_acc <= r_acc + DAT_STEP;
                        if (r_k == LAST_K) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: r_state <= ST_DONE;
                default: r_state <= ST_INIT;
            endcase
        end
    end

`ifdef HSEQ_SOURCE_STALL_CNT_EN
    logic [HSEQ_CNT_SZ-1:0] r_stall;

    always_ff @(posedge gch_clk or posedge gch_reset) begin
        if (gch_reset) begin
            r_stall <= '0;
        end else if (r_state == ST_WAIT && !w_accept && r_stall != '1) begin
            r_stall <= r_stall + 1'b1;
        end
    end

    assign stall_cnt = r_stall;
`endif

    assign gch_ready    = r_ready;
    assign snd0_src     = r_src;
    assign snd0_dst     = r_dst;
    assign snd0_dat     = r_dat;
    assign snd0_red     = r_red;
    assign snd0_req_out = r_req;
    assign done         = r_done;
    assign dbg_state    = r_state;
endmodule

// File: tb/tb_hseq_source.sv
// Bench for hseq_source: three instances (default, NUM_MSGS=0, 8-bit wrapping data) on one clock/reset.
`timescale 1ns/1ps
module tb_hseq_source;
  import hseq_pkg::*;

  localparam int ASZ = 8;
  localparam int DSZ = 16;
  localparam int RSZ = 8;
  localparam int W   = ASZ + ASZ + DSZ + RSZ;
  localparam int W2  = ASZ + ASZ + 8 + RSZ;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance 0: default parameters
  logic           rdy0, req0, done0;
  logic           ack0 = 1'b0;
  logic [ASZ-1:0] src0, dst0;
  logic [DSZ-1:0] dat0;
  logic [RSZ-1:0] red0;
  logic [1:0]     st0;
  // instance 1: NUM_MSGS = 0
  logic           rdy1, req1, done1;
  logic           ack1 = 1'b0;
  logic [ASZ-1:0] src1, dst1;
  logic [DSZ-1:0] dat1;
  logic [RSZ-1:0] red1;
  logic [1:0]     st1;
  // instance 2: DSZ=8, wraps through FF
  logic           rdy2, req2, done2;
  wire            ack2;
  logic [ASZ-1:0] src2, dst2;
  logic [7:0]     dat2;
  logic [RSZ-1:0] red2;
  logic [1:0]     st2;
  assign ack2 = req2;
`ifdef HSEQ_SOURCE_STALL_CNT_EN
  logic [15:0] stall0, stall1, stall2;
`endif

  hseq_source #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .NUM_MSGS(8)) u0 (
    .gch_clk(clk), .gch_reset(rst), .gch_ready(rdy0),
    .snd0_src(src0), .snd0_dst(dst0), .snd0_dat(dat0), .snd0_red(red0),
    .snd0_req_out(req0), .snd0_ack_in(ack0), .dbg_state(st0), .done(done0)
`ifdef HSEQ_SOURCE_STALL_CNT_EN
    , .stall_cnt(stall0)
`endif
  );

  hseq_source #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ), .NUM_MSGS(0)) u1 (
    .gch_clk(clk), .gch_reset(rst), .gch_ready(rdy1),
    .snd0_src(src1), .snd0_dst(dst1), .snd0_dat(dat1), .snd0_red(red1),
    .snd0_req_out(req1), .snd0_ack_in(ack1), .dbg_state(st1), .done(done1)
`ifdef HSEQ_SOURCE_STALL_CNT_EN
    , .stall_cnt(stall1)
`endif
  );

  hseq_source #(.ASZ(ASZ), .DSZ(8), .RSZ(RSZ), .NUM_MSGS(4),
                .DAT_START(8'hFE), .DAT_STEP(8'h01)) u2 (
    .gch_clk(clk), .gch_reset(rst), .gch_ready(rdy2),
    .snd0_src(src2), .snd0_dst(dst2), .snd0_dat(dat2), .snd0_red(red2),
    .snd0_req_out(req2), .snd0_ack_in(ack2), .dbg_state(st2), .done(done2)
`ifdef HSEQ_SOURCE_STALL_CNT_EN
    , .stall_cnt(stall2)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // scoreboard queues
  logic [W-1:0]  exp_q[$];
  logic [W2-1:0] exp2_q[$];

  // expected u0 message k: src=0, dst=1, dat=k, red=(0+1+k) mod 256
  function automatic logic [W-1:0] mk0(input int k);
    logic [DSZ-1:0] d;
    logic [RSZ-1:0] r;
    d = DSZ'(k);
    r = RSZ'(k + 1);
    return {8'h00, 8'h01, d, r};
  endfunction

  task automatic push_u0_all();
    for (int k = 0; k < 8; k++) exp_q.push_back(mk0(k));
  endtask

  task automatic push_u2_all();
    exp2_q.push_back({8'h00, 8'h01, 8'hFE, 8'hFF});
    exp2_q.push_back({8'h00, 8'h01, 8'hFF, 8'h00});
    exp2_q.push_back({8'h00, 8'h01, 8'h00, 8'h01});
    exp2_q.push_back({8'h00, 8'h01, 8'h01, 8'h02});
  endtask

  // u0 monitor + sink: new message on every req toggle, fields held while pending
  int           delay_tab[8];
  bit           sink_en = 1'b1;
  int           wcnt    = 0;
  int           msg_idx = 0;
  int           tog0    = 0;
  logic         prev_req0 = 1'b0;
  logic [W-1:0] cap0;

  always @(negedge clk) begin
    if (rst) begin
      prev_req0 = 1'b0;
      wcnt      = 0;
      msg_idx   = 0;
    end else begin
      if (req0 !== prev_req0) begin
        tog0++;
        prev_req0 = req0;
        cap0 = {src0, dst0, dat0, red0};
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL u0_extra_msg actual=%0h expected=none", cap0);
        end else begin
          chk("u0_msg", 64'(cap0), 64'(exp_q.pop_front()));
        end
      end else if (req0 !== ack0) begin
        chk("u0_stable", 64'({src0, dst0, dat0, red0}), 64'(cap0));
      end
      if (sink_en && req0 !== ack0) begin
        if (wcnt >= ((msg_idx < 8) ? delay_tab[msg_idx] : 0)) begin
          ack0 = req0;
          wcnt = 0;
          msg_idx++;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // u2 monitor (zero-latency sink)
  int   tog2 = 0;
  logic prev_req2 = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      prev_req2 = 1'b0;
    end else if (req2 !== prev_req2) begin
      tog2++;
      prev_req2 = req2;
      if (exp2_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL u2_extra_msg actual=%0h expected=none", {src2, dst2, dat2, red2});
      end else begin
        chk("u2_msg", 64'({src2, dst2, dat2, red2}), 64'(exp2_q.pop_front()));
      end
    end
  end

  task automatic wait_done0(input int budget);
    for (int c = 0; c < budget && done0 !== 1'b1; c++) @(posedge clk);
    #1;
    chk("u0_done", 64'(done0), 64'd1);
  endtask

  logic req_hold;

  initial begin
    for (int i = 0; i < 8; i++) delay_tab[i] = 0;
    delay_tab[2] = 5;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready0", 64'(rdy0), 64'd0);
    chk("rst_req0",   64'(req0), 64'd0);
    chk("rst_done0",  64'(done0), 64'd0);
    chk("rst_fields0", 64'({src0, dst0, dat0, red0}), 64'd0);
    chk("rst_state0", 64'(st0), 64'(ST_INIT));
    chk("rst_ready1", 64'(rdy1), 64'd0);

    push_u0_all();
    push_u2_all();
    @(negedge clk) rst = 1'b0;

    @(posedge clk) #1;
    chk("ready0_1clk", 64'(rdy0), 64'd1);
    chk("req0_1clk",   64'(req0), 64'd0);
    chk("ready1_1clk", 64'(rdy1), 64'd1);
    chk("done1_1clk",  64'(done1), 64'd1);
    @(posedge clk) #1;
    chk("req0_2clk", 64'(req0), 64'd1);

    wait_done0(300);
    chk("u0_toggles",   64'(tog0), 64'd8);
    chk("u0_q_empty",   64'(exp_q.size()), 64'd0);
    chk("u0_last_dat",  64'(dat0), 64'd7);
    chk("u0_last_red",  64'(red0), 64'd8);
    chk("u0_state",     64'(st0), 64'(ST_DONE));
`ifdef HSEQ_SOURCE_STALL_CNT_EN
    chk("u0_stall", 64'(stall0), 64'd5);
`endif
    chk("u2_done",    64'(done2), 64'd1);
    chk("u2_toggles", 64'(tog2), 64'd4);
    chk("u2_q_empty", 64'(exp2_q.size()), 64'd0);
    chk("u1_req",     64'(req1), 64'd0);
    chk("u1_fields",  64'({src1, dst1, dat1, red1}), 64'd0);
    chk("u1_state",   64'(st1), 64'(ST_DONE));

    // spurious acks after done
    @(negedge clk);
    sink_en  = 1'b0;
    req_hold = req0;
    ack0 = ~ack0;
    ack1 = ~ack1;
    repeat (4) @(posedge clk);
    #1;
    chk("spur_done0",  64'(done0), 64'd1);
    chk("spur_req0",   64'(req0), 64'(req_hold));
    chk("spur_state0", 64'(st0), 64'(ST_DONE));
    chk("spur_dat0",   64'(dat0), 64'd7);
    chk("spur_tog0",   64'(tog0), 64'd8);
    chk("spur_done1",  64'(done1), 64'd1);
    chk("spur_req1",   64'(req1), 64'd0);
`ifdef HSEQ_SOURCE_STALL_CNT_EN
    chk("spur_stall0", 64'(stall0), 64'd5);
`endif

    // restart with a long stall on message 3, then reset inside ST_WAIT
    @(negedge clk);
    rst  = 1'b1;
    ack0 = 1'b0;
    ack1 = 1'b0;
    for (int i = 0; i < 8; i++) delay_tab[i] = 0;
    delay_tab[3] = 20;
    for (int k = 0; k < 4; k++) exp_q.push_back(mk0(k));
    push_u2_all();
    tog0 = 0;
    tog2 = 0;
    sink_en = 1'b1;
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 200 && !(tog0 == 4 && st0 == ST_WAIT); c++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("mid_state", 64'(st0), 64'(ST_WAIT));
    chk("mid_dat",   64'(dat0), 64'd3);
    #2 rst = 1'b1;
    #1;
    chk("async_ready0", 64'(rdy0), 64'd0);
    chk("async_fields0", 64'({src0, dst0, dat0, red0}), 64'd0);
    chk("async_req0",   64'(req0), 64'd0);
    chk("async_state0", 64'(st0), 64'(ST_INIT));
    chk("async_done2",  64'(done2), 64'd0);
`ifdef HSEQ_SOURCE_STALL_CNT_EN
    chk("async_stall0", 64'(stall0), 64'd0);
`endif
    chk("mid_q_empty", 64'(exp_q.size()), 64'd0);

    // full sequence again from DAT_START
    @(negedge clk);
    ack0 = 1'b0;
    for (int i = 0; i < 8; i++) delay_tab[i] = 0;
    push_u0_all();
    exp2_q.delete();
    push_u2_all();
    tog0 = 0;
    tog2 = 0;
    @(negedge clk) rst = 1'b0;
    wait_done0(300);
    chk("re_toggles",  64'(tog0), 64'd8);
    chk("re_q_empty",  64'(exp_q.size()), 64'd0);
    chk("re_last_dat", 64'(dat0), 64'd7);
`ifdef HSEQ_SOURCE_STALL_CNT_EN
    chk("re_stall0", 64'(stall0), 64'd0);
`endif
    chk("re_u2_done",    64'(done2), 64'd1);
    chk("re_u2_q_empty", 64'(exp2_q.size()), 64'd0);
    chk("re_u2_toggles", 64'(tog2), 64'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
